// File: rtl/ktane_io_mem.sv
// Button/LED front-panel peripheral on the CPU data bus: debounced buttons with
// W1C press/release flags and masked interrupt, plus 5-bit PWM RGB LED drivers.
module ktane_io_mem #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int NUM_BUTTONS     = 8,
  parameter int NUM_LEDS        = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 16'hF330
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    we,
  input  logic                    en,
  output logic [DATA_WIDTH-1:0]   q,
  input  logic [NUM_BUTTONS-1:0]  buttons,
  output logic                    irq,
  output logic [3*NUM_LEDS-1:0]   led_pins
);

  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LIW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [CW-1:0]         DB_LAST      = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS     = ADDR_WIDTH'(4 + NUM_LEDS);
  localparam logic [ADDR_WIDTH-1:0] OFF_STATUS   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OFF_PRESSED  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OFF_RELEASED = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK     = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] OFF_LED0     = ADDR_WIDTH'(4);

  logic [NUM_BUTTONS-1:0] sync1_r, sync2_r, deb_r;
  logic [NUM_BUTTONS-1:0] pressed_r, released_r, mask_r;
  logic [CW-1:0]          cnt_r [NUM_BUTTONS];
  logic [14:0]            led_r [NUM_LEDS];
  logic [4:0]             pwm_cnt_r;
  logic [DATA_WIDTH-1:0]  q_r;
  logic                   irq_r;
  logic [3*NUM_LEDS-1:0]  pins_r;

  logic [ADDR_WIDTH-1:0]  off_s, led_off_s;
  logic                   hit_s, wr_s;
  logic [NUM_BUTTONS-1:0] flip_s, rise_s, fall_s, pw1c_s, rw1c_s;
  logic [DATA_WIDTH-1:0]  rdata_s;

  // Address decode, write strobes and read mux
  always_comb begin
    off_s     = addr - BASE_ADDR;
    led_off_s = off_s - OFF_LED0;
    hit_s     = (addr >= BASE_ADDR) && (off_s < NUM_REGS);
    wr_s      = en && we && hit_s;
    pw1c_s    = (wr_s && (off_s == OFF_PRESSED))  ? data[NUM_BUTTONS-1:0] : '0;
    rw1c_s    = (wr_s && (off_s == OFF_RELEASED)) ? data[NUM_BUTTONS-1:0] : '0;
    rdata_s   = '0;
    if (hit_s) begin
      case (off_s)
        OFF_STATUS:   rdata_s[NUM_BUTTONS-1:0] = deb_r;
        OFF_PRESSED:  rdata_s[NUM_BUTTONS-1:0] = pressed_r;
        OFF_RELEASED: rdata_s[NUM_BUTTONS-1:0] = released_r;
        OFF_MASK:     rdata_s[NUM_BUTTONS-1:0] = mask_r;
        default:      rdata_s[14:0] = led_r[led_off_s[LIW-1:0]];
      endcase
    end else begin
      rdata_s = '0;
    end
  end

  // A button flips on the edge where its mismatch run would reach DEBOUNCE_CYCLES
  always_comb begin
    flip_s = '0;
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      flip_s[b] = (sync2_r[b] != deb_r[b]) && (cnt_r[b] == DB_LAST);
    end
    rise_s = flip_s & ~deb_r;
    fall_s = flip_s & deb_r;
  end

  // Synchronisers, debounce counters and debounced levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      deb_r   <= '0;
      for (int b = 0; b < NUM_BUTTONS; b++) cnt_r[b] <= '0;
    end else begin
      sync1_r <= buttons;
      sync2_r <= sync1_r;
      deb_r   <= deb_r ^ flip_s;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        if ((sync2_r[b] == deb_r[b]) || flip_s[b]) cnt_r[b] <= '0;
        else                                       cnt_r[b] <= cnt_r[b] + CW'(1);
      end
    end
  end

  // Event flags (a new edge beats a same-cycle W1C), mask and LED colour registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_r  <= '0;
      released_r <= '0;
      mask_r     <= '0;
      for (int i = 0; i < NUM_LEDS; i++) led_r[i] <= '0;
    end else begin
      pressed_r  <= (pressed_r & ~pw1c_s) | rise_s;
      released_r <= (released_r & ~rw1c_s) | fall_s;
      if (wr_s && (off_s == OFF_MASK)) mask_r <= data[NUM_BUTTONS-1:0];
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_s && (off_s == OFF_LED0 + ADDR_WIDTH'(i))) led_r[i] <= data[14:0];
      end
    end
  end

  // Registered bus read, interrupt and PWM outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= '0;
      irq_r     <= 1'b0;
      pins_r    <= '0;
      pwm_cnt_r <= 5'd0;
    end else begin
      if (en) q_r <= rdata_s;
      irq_r     <= |(pressed_r & mask_r);
      pwm_cnt_r <= (pwm_cnt_r == 5'd30) ? 5'd0 : pwm_cnt_r + 5'd1;
      for (int i = 0; i < NUM_LEDS; i++) begin
        pins_r[3*i+2] <= (pwm_cnt_r < led_r[i][14:10]);
        pins_r[3*i+1] <= (pwm_cnt_r < led_r[i][9:5]);
        pins_r[3*i]   <= (pwm_cnt_r < led_r[i][4:0]);
      end
    end
  end

  assign q        = q_r;
  assign irq      = irq_r;
  assign led_pins = pins_r;

endmodule

// File: tb/tb_ktane_io_mem.sv
// Self-checking bench for ktane_io_mem: cycle compare against a behavioural model
// plus directed reads with hand-computed expectations.
module tb_ktane_io_mem;

  localparam int D = 4;
  localparam logic [15:0] BASE = 16'hF330;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data, addr;
  logic        we, en;
  logic [15:0] q;
  logic [7:0]  buttons;
  logic        irq;
  logic [5:0]  led_pins;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  ktane_io_mem #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_BUTTONS(8), .NUM_LEDS(2),
    .DEBOUNCE_CYCLES(D), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .addr(addr), .we(we), .en(en),
    .q(q), .buttons(buttons), .irq(irq), .led_pins(led_pins)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_deb, m_pressed, m_released, m_mask;
  logic [14:0] m_led [2];
  logic [15:0] m_q;
  logic        m_irq;
  logic [5:0]  m_pins;
  int          m_edges;
  logic [7:0]  m_raw [$];

  function automatic logic [15:0] m_read(input logic [15:0] a);
    int off;
    if (a < BASE) return 16'h0000;
    off = int'(a - BASE);
    case (off)
      0: return {8'h00, m_deb};
      1: return {8'h00, m_pressed};
      2: return {8'h00, m_released};
      3: return {8'h00, m_mask};
      4: return {1'b0, m_led[0]};
      5: return {1'b0, m_led[1]};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_reset();
    m_deb = 8'h00; m_pressed = 8'h00; m_released = 8'h00; m_mask = 8'h00;
    m_led[0] = 15'h0000; m_led[1] = 15'h0000;
    m_q = 16'h0000; m_irq = 1'b0; m_pins = 6'h00; m_edges = 0;
    m_raw.delete();
    for (int j = 0; j < D + 2; j++) m_raw.push_back(8'h00);
  endtask

  // The synced view of a button is the raw input two edges back; a level is
  // accepted once the last D synced samples all disagree with the current level.
  task automatic m_step();
    logic [7:0]  flip, w1c_p, w1c_r;
    logic [15:0] rd;
    int          pwm, off;
    bit          all;
    m_raw.push_front(buttons);
    while (m_raw.size() > D + 2) void'(m_raw.pop_back());
    flip = 8'h00;
    for (int b = 0; b < 8; b++) begin
      all = 1'b1;
      for (int j = 2; j < D + 2; j++) if (m_raw[j][b] == m_deb[b]) all = 1'b0;
      flip[b] = all;
    end
    rd  = m_read(addr);
    pwm = m_edges % 31;
    for (int i = 0; i < 2; i++) begin
      m_pins[3*i+2] = pwm < int'(m_led[i][14:10]);
      m_pins[3*i+1] = pwm < int'(m_led[i][9:5]);
      m_pins[3*i]   = pwm < int'(m_led[i][4:0]);
    end
    m_irq = |(m_pressed & m_mask);
    w1c_p = 8'h00; w1c_r = 8'h00;
    if (en && we && addr >= BASE) begin
      off = int'(addr - BASE);
      case (off)
        1: w1c_p = data[7:0];
        2: w1c_r = data[7:0];
        3: m_mask = data[7:0];
        4: m_led[0] = data[14:0];
        5: m_led[1] = data[14:0];
        default: ;
      endcase
    end
    m_pressed  = (m_pressed  & ~w1c_p) | (flip & ~m_deb);
    m_released = (m_released & ~w1c_r) | (flip &  m_deb);
    m_deb      = m_deb ^ flip;
    if (en) m_q = rd;
    m_edges++;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // Cycle compare on the inactive edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("cyc_q", q, m_q);
        chk("cyc_irq", {15'h0000, irq}, {15'h0000, m_irq});
        chk("cyc_led_pins", {10'h000, led_pins}, {10'h000, m_pins});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int off, input logic [15:0] v);
    addr = BASE + 16'(off); data = v; en = 1'b1; we = 1'b1;
    tick();
    en = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int off, input logic [15:0] exp, input string name);
    addr = BASE + 16'(off); en = 1'b1; we = 1'b0;
    tick();
    en = 1'b0;
    chk(name, q, exp);
  endtask

  initial begin
    logic [2:0] samp [62];
    int r_hi, g_hi, b_hi, per_bad;
    rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = 16'h0000; data = 16'h0000; buttons = 8'h00;
    tick(3);
    chk("rst_q", q, 16'h0000);
    chk("rst_irq", {15'h0000, irq}, 16'h0000);
    chk("rst_pins", {10'h000, led_pins}, 16'h0000);
    rst_n = 1'b1;
    chk_on = 1'b1;

    for (int i = 0; i <= 6; i++) rd(i, 16'h0000, "rst_readback");
    addr = 16'hF32F; en = 1'b1; tick(); en = 1'b0;
    chk("below_base", q, 16'h0000);
    wr(4, 16'hFFFF);
    rd(4, 16'h7FFF, "led0_bit15");
    wr(6, 16'h1234);
    rd(6, 16'h0000, "unmapped_wr");
    wr(0, 16'h00FF);
    rd(0, 16'h0000, "status_ro");
    wr(4, 16'h0000);

    // Short glitch is rejected
    buttons = 8'h08; tick(3); buttons = 8'h00; tick(10);
    rd(0, 16'h0000, "glitch_rejected");

    // Held press: STATUS flips on the 6th edge, visible in q one edge later
    addr = BASE; en = 1'b1; we = 1'b0; buttons = 8'h08;
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk("status_latency", q, (n <= 6) ? 16'h0000 : 16'h0008);
    end
    en = 1'b0;
    rd(1, 16'h0008, "pressed_b3");

    buttons = 8'h09; tick(8);
    rd(1, 16'h0009, "pressed_b03");
    wr(1, 16'h0008);
    rd(1, 16'h0001, "w1c_b3");
    buttons = 8'h08; tick(8);
    rd(2, 16'h0001, "released_b0");
    wr(1, 16'h0001);
    rd(1, 16'h0000, "w1c_b0");
    // W1C lands on the same edge the new press is accepted
    buttons = 8'h09; tick(5);
    wr(1, 16'h0001);
    rd(1, 16'h0001, "race_set_wins");

    buttons = 8'h00; tick(8);
    wr(1, 16'h00FF); wr(2, 16'h00FF); wr(3, 16'h0004);
    rd(3, 16'h0004, "mask_rb");
    buttons = 8'h08; tick(8);
    chk("irq_masked", {15'h0000, irq}, 16'h0000);
    rd(1, 16'h0008, "pressed_b3_again");
    buttons = 8'h0C;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 6) chk("irq_lag", {15'h0000, irq}, 16'h0000);
      if (n == 7) chk("irq_set", {15'h0000, irq}, 16'h0001);
    end
    wr(1, 16'h0004);
    chk("irq_hold", {15'h0000, irq}, 16'h0001);
    tick();
    chk("irq_clear", {15'h0000, irq}, 16'h0000);

    // PWM: R=31, G=0, B=10
    wr(4, 16'h7C0A);
    tick(2);
    for (int i = 0; i < 62; i++) begin samp[i] = led_pins[2:0]; tick(); end
    r_hi = 0; g_hi = 0; b_hi = 0; per_bad = 0;
    for (int i = 0; i < 31; i++) begin
      r_hi += int'(samp[i][2]); g_hi += int'(samp[i][1]); b_hi += int'(samp[i][0]);
      if (samp[i] != samp[i+31]) per_bad++;
    end
    chk("pwm_r", 16'(r_hi), 16'd31);
    chk("pwm_g", 16'(g_hi), 16'd0);
    chk("pwm_b", 16'(b_hi), 16'd10);
    chk("pwm_period", 16'(per_bad), 16'd0);

    // Reset with a debounce 2 edges from completion and LEDs lit
    buttons = 8'h0D; tick(4);
    rst_n = 1'b0; #1;
    chk("async_rst_q", q, 16'h0000);
    chk("async_rst_irq", {15'h0000, irq}, 16'h0000);
    chk("async_rst_pins", {10'h000, led_pins}, 16'h0000);
    tick(3);
    addr = BASE; en = 1'b1; we = 1'b0; rst_n = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk("post_rst_latency", q, (n <= 6) ? 16'h0000 : 16'h000D);
    end
    en = 1'b0;
    rd(1, 16'h000D, "pressed_after_rst");
    rd(4, 16'h0000, "led_after_rst");

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
